debug_trace_buffer: RTL and testbench
=====================================

Name: debug_trace_buffer

Overview:
Parametrised successor to the single-register debug output unit.
- Keeps the legacy last-value debug_dout register.
- Also records every ST/LD data-memory event, tagged by type, into a DEPTH-entry trace FIFO.
- A debug host drains the FIFO through a valid/ready port.
- Sits beside the CPU datapath, fed by the decoded opcode, the regfile read port 0 (ST data) and the data-RAM read data (LD data).

Parameters:
DATA_W, 8, width of captured data.
OPC_W, 4, opcode width.
DEPTH, 16, trace FIFO entries; must be a power of 2, minimum 2.
OP_ST, 4'h6, store opcode.
OP_LD, 4'h5, load opcode.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
capture_en  in  1  1 = ST/LD events are pushed into the FIFO.
ring_mode  in  1  0 = drop new events when full; 1 = overwrite oldest.
clear  in  1  synchronous flush of FIFO and overflow counter.
opcode  in  OPC_W  current instruction opcode.
st_data  in  DATA_W  regfile rdata0 (store data).
ld_data  in  DATA_W  data-RAM read data (load data).
debug_dout  out  DATA_W  last ST/LD data value (legacy behaviour).
trc_valid  out  1  FIFO head is valid.
trc_ready  in  1  host accepts the head.
trc_data  out  DATA_W+1  {is_ld, data} at FIFO head.
count  out  $clog2(DEPTH)+1  current occupancy.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
overflow_cnt  out  8  events dropped or overwritten; saturates at 255.

Behaviour:
Reset:
- While rst is high, all outputs and state are 0: debug_dout, pointers, count, overflow_cnt, trc_valid.
- After reset, empty = 1.

Events and debug_dout:
- An event is opcode==OP_ST or opcode==OP_LD, sampled at the clock edge.
- debug_dout is independent of capture_en and clear:
  - OP_ST → st_data.
  - OP_LD → ld_data.
  - Any other opcode → hold.
  - Latency is 1 cycle.

Push and pop:
- push = event && capture_en. The entry {opcode==OP_LD, selected data} is written at that edge.
- The FIFO is show-ahead: trc_valid = !empty, and trc_data = mem[rd_ptr] combinationally from registered state.
- pop = trc_valid && trc_ready.
- No bypass: a push into an empty FIFO becomes visible on trc_valid the next cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is registered.

Push/pop combinations:
- push && !full: write at wr_ptr; wr_ptr++.
- pop: rd_ptr++.
- count += push_accepted - pop.
- push && pop && full: both occur; count stays DEPTH; no overflow.
- push && !pop && full && ring_mode=0: entry dropped; pointers unchanged; overflow_cnt++ (saturating).
- push && !pop && full && ring_mode=1: write at wr_ptr; wr_ptr++ and rd_ptr++; count stays DEPTH; overflow_cnt++ (saturating).
- pop while empty: impossible, because trc_valid = 0.

Clear and mode changes:
- clear has priority over push and pop in the same cycle. It zeroes the pointers, count and overflow_cnt; the event in that cycle is not stored.
- Changing ring_mode or capture_en takes effect from the next edge. Stored contents are untouched.
- trc_data must remain stable while trc_valid && !trc_ready, except when ring_mode overwrite advances the head.

Decomposition:
- Shared package debug_pkg:
  - OP_LD/OP_ST opcode constants, shared with decode.
  - trace entry typedef {is_ld, data}.
  - Overflow counter width constant.
- Sub-module debug_trace_fifo:
  - Parametrised show-ahead FIFO with push, pop, overwrite and clear inputs.
  - Outputs count, full and empty.
- The top level holds debug_dout, event decode, the push/overwrite decision and overflow_cnt.

Test Plan:
1. Reset/legacy: apply rst mid-run, then opcode=6 with st_data=0xA5, then opcode=5 with ld_data=0x3C, then opcode=0 → debug_dout = 0 during reset, then 0xA5, then 0x3C, then holds 0x3C; FIFO entries are {0,A5} then {1,3C}.
2. Fill/drop: capture_en=1, ring_mode=0, trc_ready=0, 18 ST events with data 0..17 → full=1, count=16, overflow_cnt=2; draining returns 0..15 in order.
3. Ring overwrite: same as test 2 with ring_mode=1 → overflow_cnt=2; draining returns 2..17; full deasserts after the first pop.
4. Simultaneous push and pop at full: trc_ready=1 with one event per cycle for 10 cycles → count stays 16, overflow_cnt stays 0, output order is preserved.
5. Clear priority: clear=1 together with an event and a pop on a FIFO holding 5 entries → next cycle count=0, empty=1, overflow_cnt=0, and debug_dout is still updated by that event.
6. Saturation and gating: 300 overflowing pushes → overflow_cnt=255. With capture_en=0, events update only debug_dout and count is unchanged.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared debug/trace definitions: opcode constants common with decode,
// the trace entry layout and the overflow counter width.
package debug_pkg;

   localparam logic [3:0] OP_LD = 4'h5;
   localparam logic [3:0] OP_ST = 4'h6;

   localparam int OVF_W        = 8;
   localparam int TRACE_DATA_W = 8;

   typedef struct packed {
      logic                    is_ld;
      logic [TRACE_DATA_W-1:0] data;
   } trace_entry_t;

   // Saturating increment for the overflow counter.
   function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
      return (&v) ? v : v + OVF_W'(1);
   endfunction

endpackage

// File: rtl/debug_trace_fifo.sv
// Show-ahead FIFO with optional overwrite-oldest on full and a synchronous
// clear. The head is presented combinationally from registered state.
module debug_trace_fifo #(
   parameter int W     = 9,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       overwrite,
   input  logic                       clear,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop;
   logic          do_write;
   logic          adv_rd;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   // A full FIFO still accepts a push when the head leaves in the same cycle
   // or when the oldest entry may be overwritten (which also advances the head).
   assign do_pop   = pop && !empty;
   assign do_write = push && (!full || do_pop || overwrite);
   assign adv_rd   = do_pop || (push && full && overwrite);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + AW'(1);
         if (adv_rd)   rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_write) - CW'(adv_rd);
      end
   end

   // NOTE: the storage array has no reset; validity is tracked by count alone,
   // which keeps the array mappable to plain RAM.
   always_ff @(posedge clk) begin
      if (do_write && !clear) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/debug_trace_buffer.sv
// Legacy last-value debug register plus a tagged ST/LD trace FIFO drained by
// a debug host over valid/ready, with a saturating overflow counter.
module debug_trace_buffer
   import debug_pkg::*;
#(
   parameter int               DATA_W = 8,
   parameter int               OPC_W  = 4,
   parameter int               DEPTH  = 16,
   parameter logic [OPC_W-1:0] OP_ST  = OPC_W'(debug_pkg::OP_ST),
   parameter logic [OPC_W-1:0] OP_LD  = OPC_W'(debug_pkg::OP_LD)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   capture_en,
   input  logic                   ring_mode,
   input  logic                   clear,
   input  logic [OPC_W-1:0]       opcode,
   input  logic [DATA_W-1:0]      st_data,
   input  logic [DATA_W-1:0]      ld_data,
   output logic [DATA_W-1:0]      debug_dout,
   output logic                   trc_valid,
   input  logic                   trc_ready,
   output logic [DATA_W:0]        trc_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty,
   output logic [OVF_W-1:0]       overflow_cnt
);

   logic              is_st;
   logic              is_ld;
   logic              push;
   logic              pop;
   logic              ovf_event;
   logic [DATA_W-1:0] sel_data;

   assign is_st    = (opcode == OP_ST);
   assign is_ld    = (opcode == OP_LD);
   assign sel_data = is_ld ? ld_data : st_data;
   assign push     = (is_st || is_ld) && capture_en;
   assign pop      = trc_valid && trc_ready;
   assign trc_valid = !empty;

   // Full without a simultaneous pop loses an entry: the new one when
   // dropping, the oldest one when overwriting. Either counts as overflow.
   assign ovf_event = push && full && !pop && !clear;

   debug_trace_fifo #(
      .W     (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .overwrite (ring_mode),
      .clear     (clear),
      .din       ({is_ld, sel_data}),
      .dout      (trc_data),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   // Legacy register follows every ST/LD regardless of capture_en and clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         debug_dout <= '0;
      end else if (is_st) begin
         debug_dout <= st_data;
      end else if (is_ld) begin
         debug_dout <= ld_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_cnt <= '0;
      end else if (clear) begin
         overflow_cnt <= '0;
      end else if (ovf_event) begin
         overflow_cnt <= sat_inc(overflow_cnt);
      end
   end

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Directed bench for debug_trace_buffer: stimulus queues hand-computed trace
// entries, a negedge monitor compares every accepted FIFO head against them.
module tb_debug_trace_buffer;
   import debug_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       capture_en;
   logic       ring_mode;
   logic       clear;
   logic [3:0] opcode;
   logic [7:0] st_data;
   logic [7:0] ld_data;
   logic [7:0] debug_dout;
   logic       trc_valid;
   logic       trc_ready;
   logic [8:0] trc_data;
   logic [4:0] count;
   logic       full;
   logic       empty;
   logic [7:0] overflow_cnt;

   int tests = 0;
   int fails = 0;
   trace_entry_t sb[$];

   debug_trace_buffer dut (
      .clk          (clk),
      .rst          (rst),
      .capture_en   (capture_en),
      .ring_mode    (ring_mode),
      .clear        (clear),
      .opcode       (opcode),
      .st_data      (st_data),
      .ld_data      (ld_data),
      .debug_dout   (debug_dout),
      .trc_valid    (trc_valid),
      .trc_ready    (trc_ready),
      .trc_data     (trc_data),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .overflow_cnt (overflow_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic trace_entry_t ent(input logic is_ld, input logic [7:0] d);
      trace_entry_t e;
      e.is_ld = is_ld;
      e.data  = d;
      return e;
   endfunction

   // Inputs change 1 time unit after the active edge; state is read there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ev(input logic [3:0] op, input logic [7:0] s, input logic [7:0] l);
      opcode  = op;
      st_data = s;
      ld_data = l;
      tick();
      opcode  = 4'h0;
   endtask

   task automatic drain(input int n);
      trc_ready = 1'b1;
      repeat (n) tick();
      trc_ready = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Monitor: a handshake seen at the negedge completes at the next posedge.
   initial begin
      trace_entry_t exp_e;
      forever begin
         @(negedge clk);
         if (!rst && trc_valid && trc_ready) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL pop_unexpected: got 0x%0h expected no entry", trc_data);
            end else begin
               exp_e = sb.pop_front();
               check("trc_data", 32'(trc_data), 32'(exp_e));
            end
         end
      end
   end

   initial begin
      #200000;
      fails++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      rst = 1'b1; capture_en = 1'b0; ring_mode = 1'b0; clear = 1'b0;
      opcode = 4'h0; st_data = 8'h00; ld_data = 8'h00; trc_ready = 1'b0;
      repeat (2) tick();
      rst = 1'b0;

      // 1: legacy register, mid-run reset, tagged entries
      ev(4'h6, 8'h11, 8'h00);
      check("dout_pre_rst", debug_dout, 8'h11);
      rst = 1'b1;
      #2;
      check("rst_dout", debug_dout, 8'h00);
      check("rst_valid", trc_valid, 1'b0);
      check("rst_count", count, 5'd0);
      check("rst_ovf", overflow_cnt, 8'd0);
      tick();
      rst = 1'b0;
      check("rst_empty", empty, 1'b1);
      capture_en = 1'b1;
      sb.push_back(ent(1'b0, 8'hA5));
      sb.push_back(ent(1'b1, 8'h3C));
      ev(4'h6, 8'hA5, 8'hFF);
      check("dout_st", debug_dout, 8'hA5);
      check("valid_after_push", trc_valid, 1'b1);
      ev(4'h5, 8'hEE, 8'h3C);
      check("dout_ld", debug_dout, 8'h3C);
      ev(4'h0, 8'h77, 8'h88);
      check("dout_hold", debug_dout, 8'h3C);
      check("t1_count", count, 5'd2);
      drain(2);
      check("t1_empty", empty, 1'b1);

      // 2: fill and drop
      for (int i = 0; i < 18; i++) ev(4'h6, 8'(i), 8'h00);
      check("t2_full", full, 1'b1);
      check("t2_count", count, 5'd16);
      check("t2_ovf", overflow_cnt, 8'd2);
      for (int i = 0; i < 16; i++) sb.push_back(ent(1'b0, 8'(i)));
      drain(16);
      check("t2_empty", empty, 1'b1);
      do_clear();
      check("t2_ovf_clr", overflow_cnt, 8'd0);

      // 3: ring overwrite
      ring_mode = 1'b1;
      for (int i = 0; i < 18; i++) ev(4'h6, 8'(i), 8'h00);
      check("t3_ovf", overflow_cnt, 8'd2);
      check("t3_count", count, 5'd16);
      for (int i = 2; i < 18; i++) sb.push_back(ent(1'b0, 8'(i)));
      drain(1);
      check("t3_full_after_pop", full, 1'b0);
      check("t3_count_after_pop", count, 5'd15);
      drain(15);
      check("t3_empty", empty, 1'b1);
      do_clear();
      ring_mode = 1'b0;

      // 4: simultaneous push and pop at full
      for (int i = 0; i < 16; i++) ev(4'h6, 8'h40 + 8'(i), 8'h00);
      for (int i = 0; i < 16; i++) sb.push_back(ent(1'b0, 8'h40 + 8'(i)));
      for (int i = 0; i < 10; i++) sb.push_back(ent(1'b0, 8'h80 + 8'(i)));
      trc_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         ev(4'h6, 8'h80 + 8'(i), 8'h00);
         check("t4_count", count, 5'd16);
         check("t4_ovf", overflow_cnt, 8'd0);
      end
      drain(16);
      check("t4_empty", empty, 1'b1);

      // 6: saturation, then capture gating
      for (int i = 0; i < 316; i++) ev(4'h6, 8'(i), 8'h00);
      check("t6_ovf_sat", overflow_cnt, 8'd255);
      check("t6_count", count, 5'd16);
      for (int i = 0; i < 16; i++) sb.push_back(ent(1'b0, 8'(i)));
      capture_en = 1'b0;
      ev(4'h5, 8'h00, 8'h99);
      check("t6_gate_dout_ld", debug_dout, 8'h99);
      check("t6_gate_count", count, 5'd16);
      check("t6_gate_ovf", overflow_cnt, 8'd255);
      ev(4'h6, 8'h55, 8'h00);
      check("t6_gate_dout_st", debug_dout, 8'h55);
      check("t6_gate_count2", count, 5'd16);
      capture_en = 1'b1;
      drain(16);
      check("t6_empty", empty, 1'b1);

      // 5: clear beats a concurrent push and pop
      for (int i = 0; i < 5; i++) ev(4'h6, 8'h20 + 8'(i), 8'h00);
      check("t5_count", count, 5'd5);
      check("t5_ovf_before", overflow_cnt, 8'd255);
      sb.push_back(ent(1'b0, 8'h20));
      clear     = 1'b1;
      trc_ready = 1'b1;
      ev(4'h5, 8'h00, 8'h77);
      clear     = 1'b0;
      trc_ready = 1'b0;
      check("t5_count_clr", count, 5'd0);
      check("t5_empty_clr", empty, 1'b1);
      check("t5_valid_clr", trc_valid, 1'b0);
      check("t5_ovf_clr", overflow_cnt, 8'd0);
      check("t5_dout", debug_dout, 8'h77);
      tick();
      check("t5_count_after", count, 5'd0);

      check("sb_left", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
